// File: rtl/tinycpu_pkg.sv
// Shared widths and fetch FSM encoding for the tinycpu datapath blocks.
// The PC and controller use the same widths.
package tinycpu_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;
    localparam int OPC_W   = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        DONE = ST_DONE,
        ERR  = ST_ERR
    } fetch_state_t;

endpackage

// File: rtl/fetch_timer.sv
// Counts REQ cycles without a memory ack.
// The expired output is asserted on the last cycle that is allowed.
module fetch_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // REQ leaves at TIMEOUT-1, so cnt never reaches the wrap point.
    assign expired = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ir_fetch.sv
// Instruction fetch stage: performs a req/ack read of program memory at pc_in,
// latches the word into the IR and splits it into opcode and offset fields.
module ir_fetch #(
    parameter int ADDR_W  = tinycpu_pkg::ADDR_W,
    parameter int INSTR_W = tinycpu_pkg::INSTR_W,
    parameter int OPC_W   = tinycpu_pkg::OPC_W,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_start,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir_out,
    output logic [OPC_W-1:0]   opcode,
    output logic [7:0]         offset_addr,
    output logic               ir_valid,
    output logic               pc_inc,
    output logic               busy,
    output logic               fetch_err
);

    import tinycpu_pkg::*;

    fetch_state_t        state;
    logic [ADDR_W-1:0]   addr_q;
    logic                expired;
    logic                timer_clear;
    logic                timer_inc;

    assign timer_clear = (state == IDLE);
    assign timer_inc   = (state == REQ) && !flush && !mem_ack && !expired;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .inc     (timer_inc),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            ir_out    <= '0;
            fetch_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_start && !flush) begin
                        addr_q    <= pc_in;
                        fetch_err <= 1'b0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // A flush wins over a same-cycle ack: the word belongs to the abandoned path.
                    if (flush) begin
                        state <= IDLE;
                    end else if (mem_ack) begin
                        ir_out <= mem_rdata;
                        state  <= DONE;
                    end else if (expired) begin
                        fetch_err <= 1'b1;
                        state     <= ERR;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from registers only, so no input reaches them combinationally.
    assign mem_addr    = addr_q;
    assign mem_rd      = (state == REQ);
    assign ir_valid    = (state == DONE);
    assign pc_inc      = (state == DONE);
    assign busy        = (state != IDLE);
    assign opcode      = ir_out[INSTR_W-1 -: OPC_W];
    assign offset_addr = ir_out[7:0];

endmodule
